// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: valid/ready request side of the data-memory port,
// pipeline stall generation, load lane alignment/extension. Optional macro: MEM_TIMEOUT_EN.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        valid_mem,
    input  logic        re_mem,
    input  logic        we_mem_mem,
    input  logic [2:0]  memop_mem,
    input  logic [63:0] addr_mem,
    input  logic [63:0] wdata_mem,
    input  logic        flush,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_req_we,
    output logic [63:0] dmem_req_addr,
    output logic [63:0] dmem_req_wdata,
    output logic [7:0]  dmem_req_wmask,
    input  logic        dmem_resp_valid,
    input  logic [63:0] dmem_resp_rdata,
    output logic        stall_mem,
    output logic [63:0] dmem_mem,
    output logic        except_misalign,
    output logic [3:0]  except_cause
);

    typedef enum logic [2:0] {IDLE, REQ, RESP, DRAIN, DONE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  memop_q;
    logic [2:0]  off_q;
    logic        squash;
    logic        access, misaligned, misalign_exc, start, kill;
    logic [7:0]  sizemask;
    logic [63:0] rshift, load_ext;
    logic        load_unsigned;
    logic        to_hit, to_flag;

    assign access       = re_mem | we_mem_mem;
    assign misalign_exc = (state == IDLE) & valid_mem & access & misaligned;
    assign start        = (state == IDLE) & valid_mem & access & ~flush & ~misaligned;
    assign kill         = squash | flush;

    always_comb begin
        misaligned = 1'b0;
        sizemask   = 8'hFF;
        case (memop_mem[1:0])
            2'b00:   begin misaligned = 1'b0;            sizemask = 8'h01; end
            2'b01:   begin misaligned = addr_mem[0];     sizemask = 8'h03; end
            2'b10:   begin misaligned = |addr_mem[1:0];  sizemask = 8'h0F; end
            default: begin misaligned = |addr_mem[2:0];  sizemask = 8'hFF; end
        endcase
    end

    // funct3 111 has size bits 11 and is therefore handled as a signed doubleword
    assign load_unsigned = memop_q[2] & ~(&memop_q[1:0]);
    assign rshift        = dmem_resp_rdata >> {off_q, 3'b000};

    always_comb begin
        load_ext = rshift;
        case (memop_q[1:0])
            2'b00:   load_ext = load_unsigned ? {56'd0, rshift[7:0]}  : {{56{rshift[7]}},  rshift[7:0]};
            2'b01:   load_ext = load_unsigned ? {48'd0, rshift[15:0]} : {{48{rshift[15]}}, rshift[15:0]};
            2'b10:   load_ext = load_unsigned ? {32'd0, rshift[31:0]} : {{32{rshift[31]}}, rshift[31:0]};
            default: load_ext = rshift;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] to_cnt;

    // the final waiting cycle without a response is the one where the count reaches the limit
    assign to_hit = ((state == RESP) || (state == DRAIN)) && !dmem_resp_valid &&
                    (to_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else begin
            if (state == REQ)
                to_cnt <= '0;
            else if ((state == RESP) || (state == DRAIN))
                to_cnt <= to_cnt + 1'b1;
            to_flag <= to_hit && (state == RESP) && !kill;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign to_hit  = 1'b0;
    assign to_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = REQ;
            REQ:     if (dmem_req_ready) state_nxt = kill ? DRAIN : RESP;
            RESP:    if (dmem_resp_valid || to_hit) state_nxt = kill ? IDLE : DONE;
            DRAIN:   if (dmem_resp_valid || to_hit) state_nxt = IDLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dmem_req_valid  = (state == REQ);
        stall_mem       = start | (state == REQ) | (state == RESP) | (state == DRAIN);
        except_misalign = misalign_exc | to_flag;
        except_cause    = 4'd0;
        if (to_flag)
            except_cause = dmem_req_we ? 4'd7 : 4'd5;
        else if (misalign_exc)
            except_cause = we_mem_mem ? 4'd6 : 4'd4;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dmem_req_we    <= 1'b0;
            dmem_req_addr  <= '0;
            dmem_req_wdata <= '0;
            dmem_req_wmask <= '0;
            dmem_mem       <= '0;
            memop_q        <= '0;
            off_q          <= '0;
            squash         <= 1'b0;
        end else begin
            if (start) begin
                dmem_req_we    <= we_mem_mem;
                dmem_req_addr  <= {addr_mem[63:3], 3'b000};
                dmem_req_wdata <= wdata_mem << {addr_mem[2:0], 3'b000};
                dmem_req_wmask <= we_mem_mem ? (sizemask << addr_mem[2:0]) : 8'h00;
                memop_q        <= memop_mem;
                off_q          <= addr_mem[2:0];
                squash         <= 1'b0;
            end else if (flush && ((state == REQ) || (state == RESP) || (state == DRAIN))) begin
                squash <= 1'b1;
            end
            if ((state == RESP) && dmem_resp_valid && !kill && !dmem_req_we)
                dmem_mem <= load_ext;
        end
    end

endmodule
